// File: rtl/leds_axil_slave_if.sv
// rtl/leds_axil_slave_if.sv - AXI4-Lite bus bundle for the LED peripheral control port
interface leds_axil_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/leds_axil_slave.sv
// rtl/leds_axil_slave.sv - AXI4-Lite LED register slave; optional blink engine under LEDS_BLINK_EN
module leds_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_LEDS           = 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  leds_axil_slave_if.slave    s_axi,
  output logic [NUM_LEDS-1:0] LEDS
);
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  // 0: LED_VAL, 1: CTRL, 2: PERIOD, 3: SCRATCH
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

  logic                          bus_active;
  logic                          awready, wready, bvalid, arready, rvalid;
  logic                          aw_hs, w_hs, ar_hs;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]             w_strb_q;
  logic                          wr_en;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]             wr_strb;
  logic [1:0]                    wr_sel;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  assign aw_hs  = s_axi.awvalid & awready;
  assign w_hs   = s_axi.wvalid & wready;
  assign ar_hs  = s_axi.arvalid & arready;
  assign wr_sel = wr_addr[3:2];

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;

  // Holds the idle readies low through reset and the cycle in which reset is released
  always_ff @(posedge ACLK) begin
    if (ARESET) bus_active <= 1'b0;
    else        bus_active <= 1'b1;
  end

  // Write FSM state register
  always_ff @(posedge ACLK) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // Write FSM next state: AW and W may arrive together or in either order
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_RESP;
        else if (aw_hs)    w_next = W_HAVE_AW;
        else if (w_hs)     w_next = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)          w_next = W_RESP;
      W_HAVE_W:  if (aw_hs)         w_next = W_RESP;
      W_RESP:    if (s_axi.bready)  w_next = W_IDLE;
      default:                      w_next = W_IDLE;
    endcase
  end

  // Write FSM outputs: readies and response valid decoded from state
  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = bus_active;
        wready  = bus_active;
      end
      W_HAVE_AW: wready  = 1'b1;
      W_HAVE_W:  awready = 1'b1;
      W_RESP:    bvalid  = 1'b1;
      default: ;
    endcase
  end

  // Captures whichever half of a write arrives first
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= s_axi.awaddr;
      if (w_hs) begin
        w_data_q <= s_axi.wdata;
        w_strb_q <= s_axi.wstrb;
      end
    end
  end

  // Commit strobe: fires on the second handshake, merging latched and live halves
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = s_axi.awaddr;
    wr_data = s_axi.wdata;
    wr_strb = s_axi.wstrb;
    case (w_state)
      W_IDLE:    wr_en = aw_hs & w_hs;
      W_HAVE_AW: begin
        wr_en   = w_hs;
        wr_addr = aw_addr_q;
      end
      W_HAVE_W: begin
        wr_en   = aw_hs;
        wr_data = w_data_q;
        wr_strb = w_strb_q;
      end
      default: ;
    endcase
  end

  // Register file with per-byte write enables
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int r = 0; r < 4; r++) regs[r] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (wr_strb[k]) regs[wr_sel][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  // Read FSM next state
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)        r_next = R_DATA;
      R_DATA:  if (s_axi.rready) r_next = R_IDLE;
      default:                   r_next = R_IDLE;
    endcase
  end

  // Read FSM outputs
  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE:  arready = bus_active;
      R_DATA:  rvalid  = 1'b1;
      default: ;
    endcase
  end

  // Read data captured at AR handshake, so a same-edge write is not yet visible
  always_ff @(posedge ACLK) begin
    if (ARESET)     rdata_q <= '0;
    else if (ar_hs) rdata_q <= regs[s_axi.araddr[3:2]];
  end

`ifdef LEDS_BLINK_EN
  logic [31:0] blink_cnt;
  logic        blink_phase;
  logic        cfg_write;

  assign cfg_write = wr_en && ((wr_sel == 2'd1) || (wr_sel == 2'd2));

  // Blink timebase: count to PERIOD inclusive, then flip phase; reconfiguring restarts it
  always_ff @(posedge ACLK) begin
    if (ARESET || cfg_write || !regs[1][0]) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == regs[2]) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end

  // LED drive, blanked during the off phase
  always_ff @(posedge ACLK) begin
    if (ARESET)           LEDS <= '0;
    else if (blink_phase) LEDS <= '0;
    else                  LEDS <= regs[0][NUM_LEDS-1:0];
  end
`else
  // LED drive follows LED_VAL one cycle later
  always_ff @(posedge ACLK) begin
    if (ARESET) LEDS <= '0;
    else        LEDS <= regs[0][NUM_LEDS-1:0];
  end
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, s_axi.awprot, s_axi.arprot, s_axi.araddr[1:0], wr_addr[1:0]};

endmodule
